// File: rtl/bn_demux_1_n_stream_if.sv
// Stream bus for the 1-to-N demultiplexer: one producer port and N flattened consumer channels.
// With DEMUX_BROADCAST_EN defined the bus also carries in_bcast.
interface bn_demux_1_n_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
);
  localparam int N = 2 ** SEL_WIDTH;

  logic [DATA_WIDTH-1:0]   in_data;
  logic [SEL_WIDTH-1:0]    in_sel;
  logic                    in_valid;
  logic                    in_ready;
`ifdef DEMUX_BROADCAST_EN
  logic                    in_bcast;
`endif
  logic [N*DATA_WIDTH-1:0] out_data;
  logic [N-1:0]            out_valid;
  logic [N-1:0]            out_ready;
  logic                    pending;

  // valid/ready: a word moves on a rising edge where valid and ready are both 1;
  // a raised valid keeps its data stable until that edge, and ready never waits on valid.
  modport master (
`ifdef DEMUX_BROADCAST_EN
    output in_bcast,
`endif
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, pending
  );

  modport slave (
`ifdef DEMUX_BROADCAST_EN
    input  in_bcast,
`endif
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, pending
  );
endinterface

// File: rtl/bn_demux_1_n_stream.sv
// Registered 1-to-N stream demultiplexer with a one-entry holding register per channel.
// Optional broadcast mode (in_bcast loads every channel) is enabled by DEMUX_BROADCAST_EN.
module bn_demux_1_n_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  bn_demux_1_n_stream_if.slave  bus
);
  localparam int N = 2 ** SEL_WIDTH;

  logic [DATA_WIDTH-1:0] data_q [N];
  logic [DATA_WIDTH-1:0] data_d [N];
  logic [N-1:0]          valid_q;
  logic [N-1:0]          valid_d;

  logic [N-1:0]          chan_ok;
  logic [N-1:0]          load;
  logic                  in_ready_w;
  logic                  in_fire;
  logic                  bcast;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = bus.in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // A channel can take a word when empty or when its current word leaves this cycle.
  always_comb begin
    chan_ok    = ~valid_q | bus.out_ready;
    in_ready_w = rst_n & chan_ok[bus.in_sel];
    if (bcast) begin
      in_ready_w = rst_n & (&chan_ok);
    end
    in_fire = bus.in_valid & in_ready_w;
  end

  always_comb begin
    load    = '0;
    valid_d = valid_q;
    for (int i = 0; i < N; i++) begin
      data_d[i] = data_q[i];
      load[i]   = in_fire & (bcast | (bus.in_sel == SEL_WIDTH'(i)));
      if (load[i]) begin
        data_d[i]  = bus.in_data;
        valid_d[i] = 1'b1;
      end else if (valid_q[i] & bus.out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < N; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign bus.out_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = valid_q;
  assign bus.pending   = |valid_q;
endmodule

// File: tb/tb_bn_demux_1_n_stream.sv
// Bench for bn_demux_1_n_stream: directed steps plus random traffic against a per-channel queue model.
// Broadcast steps are included when DEMUX_BROADCAST_EN is defined.
module tb_bn_demux_1_n_stream;
  localparam int W  = 8;
  localparam int SW = 2;
  localparam int N  = 4;

  logic clk;
  logic rst_n;

  bn_demux_1_n_stream_if #(.DATA_WIDTH(W), .SEL_WIDTH(SW)) bus ();

  bn_demux_1_n_stream #(.DATA_WIDTH(W), .SEL_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: each channel is a queue of words waiting to leave (depth 0 or 1).
  logic [W-1:0] exp_q [N][$];
  logic [W-1:0] last_data [N];
  logic [W-1:0] fire_log [N][$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic         bc;
    logic [N-1:0] ev;
    logic [N-1:0] ok;
    logic         erdy;
    logic [N*W-1:0] ed;
    logic [W-1:0] w;
    @(negedge clk);
    bc = 1'b0;
`ifdef DEMUX_BROADCAST_EN
    bc = bus.in_bcast;
`endif
    for (int i = 0; i < N; i++) begin
      ev[i] = (exp_q[i].size() != 0);
      ed[i*W +: W] = last_data[i];
    end
    ok = ~ev | bus.out_ready;
    if (!rst_n)    erdy = 1'b0;
    else if (bc)   erdy = &ok;
    else           erdy = ok[bus.in_sel];
    check("in_ready",  64'(bus.in_ready),  64'(erdy));
    check("out_valid", 64'(bus.out_valid), 64'(ev));
    check("out_data",  64'(bus.out_data),  64'(ed));
    check("pending",   64'(bus.pending),   64'(ev != '0));
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        exp_q[i].delete();
        last_data[i] = '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ev[i] && bus.out_ready[i]) begin
          w = exp_q[i].pop_front();
          fire_log[i].push_back(w);
        end
      end
      if (bus.in_valid && erdy) begin
        for (int i = 0; i < N; i++) begin
          if (bc || (bus.in_sel == SW'(i))) begin
            exp_q[i].push_back(bus.in_data);
            last_data[i] = bus.in_data;
          end
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [SW-1:0] sel, input logic [W-1:0] d,
                       input logic [N-1:0] ordy);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.out_ready = ordy;
    step();
  endtask

  initial begin
    logic [W-1:0] tmp;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sel    = '0;
    bus.in_data   = 8'h5A;
    bus.out_ready = '0;
`ifdef DEMUX_BROADCAST_EN
    bus.in_bcast  = 1'b0;
`endif
    for (int i = 0; i < N; i++) last_data[i] = '0;
    #1;

    // Reset held two cycles with in_valid asserted
    drive(1'b1, 2'd1, 8'h5A, 4'b1111);
    drive(1'b1, 2'd2, 8'h6B, 4'b0000);
    rst_n = 1'b1;

    // Unicast to each channel with all consumers stalled
    drive(1'b1, 2'd0, 8'hA0, 4'b0000);
    drive(1'b1, 2'd1, 8'hB1, 4'b0000);
    drive(1'b1, 2'd2, 8'hC2, 4'b0000);
    drive(1'b1, 2'd3, 8'hD3, 4'b0000);
    check("all_valid", 64'(bus.out_valid), 64'h0F);
    check("all_data",  64'(bus.out_data),  64'hD3C2B1A0);
    check("full_stall_ready", 64'(bus.in_ready), 64'h0);
    drive(1'b1, 2'd2, 8'hEE, 4'b0000);

    // Back-pressure isolation: drain ch3 only, then refill it while ch1 stays full
    drive(1'b0, 2'd0, 8'h00, 4'b1000);
    drive(1'b1, 2'd3, 8'h55, 4'b0000);
    check("iso_ch3_valid", 64'(bus.out_valid[3]), 64'h1);
    check("iso_ch1_data",  64'(bus.out_data[15:8]), 64'hB1);
    check("iso_ch1_valid", 64'(bus.out_valid[1]), 64'h1);

    // Simultaneous drain and load on channel 0
    drive(1'b0, 2'd0, 8'h00, 4'b0001);
    drive(1'b1, 2'd0, 8'h11, 4'b0000);
    drive(1'b1, 2'd0, 8'h22, 4'b0001);
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    check("dl_slice0", 64'(bus.out_data[7:0]), 64'h22);
    check("dl_valid0", 64'(bus.out_valid[0]), 64'h1);
    tmp = fire_log[0][fire_log[0].size()-1];
    check("dl_fired11", 64'(tmp), 64'h11);

    // Streaming 0..15 to channel 2 with its consumer always ready
    fire_log[2].delete();
    for (int k = 0; k < 16; k++) drive(1'b1, 2'd2, W'(k), 4'b0100);
    drive(1'b0, 2'd0, 8'h00, 4'b0100);
    check("stream_count", 64'(fire_log[2].size()), 64'd17);
    if (fire_log[2].size() == 17) begin
      check("stream_first", 64'(fire_log[2][0]), 64'hC2);
      for (int k = 0; k < 16; k++) check("stream_order", 64'(fire_log[2][k+1]), 64'(k));
    end

`ifdef DEMUX_BROADCAST_EN
    // Broadcast blocked by a stalled channel 3, then released
    drive(1'b0, 2'd0, 8'h00, 4'b1111);
    drive(1'b1, 2'd3, 8'h99, 4'b0000);
    bus.in_bcast = 1'b1;
    drive(1'b1, 2'd1, 8'h7E, 4'b0111);
    check("bc_blocked_valid3_data", 64'(bus.out_data[31:24]), 64'h99);
    drive(1'b1, 2'd1, 8'h7E, 4'b1111);
    bus.in_bcast = 1'b0;
    check("bc_all_valid", 64'(bus.out_valid), 64'h0F);
    check("bc_all_data",  64'(bus.out_data),  64'h7E7E7E7E);
    drive(1'b0, 2'd0, 8'h00, 4'b1111);
`endif

    // Random traffic with occasional mid-operation reset
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 49) != 0);
`ifdef DEMUX_BROADCAST_EN
      bus.in_bcast = ($urandom_range(0, 7) == 0);
`endif
      drive(1'($urandom_range(0, 1)), SW'($urandom_range(0, N-1)), W'($urandom),
            N'($urandom_range(0, 15)));
    end
    rst_n = 1'b1;
`ifdef DEMUX_BROADCAST_EN
    bus.in_bcast = 1'b0;
`endif
    drive(1'b0, 2'd0, 8'h00, 4'b1111);
    drive(1'b0, 2'd0, 8'h00, 4'b1111);
    check("drained_pending", 64'(bus.pending), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
